// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: default widths, buffer depth
// and the buffer-state encoding used by the top-level FSM.
package writeback_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int RA_WIDTH   = 5;
    localparam int PC_WIDTH   = 32;
    localparam int WB_DEPTH   = 2;
    localparam int CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_BUSY  = 2'd1,
        WB_FULL  = 2'd2
    } wb_state_e;

    // Width of an occupancy count able to hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bus between execute, the writeback stage and the GPR file write port.
// master: the surroundings (execute, GPR file, forwarding consumer).
// slave:  the writeback stage itself.
interface writeback_stage_if
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int RA_W   = RA_WIDTH,
    parameter int PC_W   = PC_WIDTH
);
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic [PC_W-1:0]   ex_pc;
    logic [RA_W-1:0]   ex_rd;
    logic              ex_ready;

    logic              wb_we;
    logic [RA_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [PC_W-1:0]   wb_pc;
    logic              wb_ack;

    logic [RA_W-1:0]   fwd_rs;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output ex_valid, ex_result, ex_pc, ex_rd, wb_ack, fwd_rs,
        input  ex_ready, wb_we, wb_addr, wb_data, wb_pc, fwd_hit, fwd_data
    );

    modport slave (
        input  ex_valid, ex_result, ex_pc, ex_rd, wb_ack, fwd_rs,
        output ex_ready, wb_we, wb_addr, wb_data, wb_pc, fwd_hit, fwd_data
    );
endinterface

// File: rtl/writeback_stage_fifo.sv
// In-order result buffer for the writeback stage: storage, read/write
// pointers and occupancy. Entries are also presented in age order
// (index 0 = head/oldest) so the top level can look ahead and search them.
module writeback_stage_fifo #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [RA_W-1:0]        in_rd,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [PC_W-1:0]        in_pc,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [DEPTH-1:0]       ord_valid,
    output logic [RA_W-1:0]        ord_rd   [DEPTH],
    output logic [DATA_W-1:0]      ord_data [DEPTH],
    output logic [PC_W-1:0]        ord_pc   [DEPTH]
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [RA_W-1:0]   mem_rd_r   [DEPTH];
    logic [DATA_W-1:0] mem_data_r [DEPTH];
    logic [PC_W-1:0]   mem_pc_r   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [OCC_W-1:0]  occ_r;

    // Capture the incoming entry; a flush only needs the pointers cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_rd_r[wr_ptr_r]   <= in_rd;
            mem_data_r[wr_ptr_r] <= in_data;
            mem_pc_r[wr_ptr_r]   <= in_pc;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Age-ordered view of the buffer, oldest entry first.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = {PTR_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            idx          = rd_ptr_r + PTR_W'(k);
            ord_valid[k] = (OCC_W'(k) < occ_r);
            ord_rd[k]    = mem_rd_r[idx];
            ord_data[k]  = mem_data_r[idx];
            ord_pc[k]    = mem_pc_r[idx];
        end
    end

    assign occupancy = occ_r;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: buffers completed execute results in order and retires
// them to the GPR file over a valid/ack write port. Entries targeting r0 are
// accepted and counted but never written. The write-port outputs are
// registered copies of the head entry and hold their value when empty.
// Optional forwarding search is enabled by defining WB_FORWARD_EN; without
// it fwd_hit and fwd_data are tied to zero.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int RA_W   = RA_WIDTH,
    parameter int DEPTH  = WB_DEPTH,
    parameter int CNT_W  = CNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    writeback_stage_if.slave       bus,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       retire_cnt
);
    localparam int OCC_W = occ_width(DEPTH);
    localparam int PC_W  = PC_WIDTH;

    wb_state_e         state_r;
    wb_state_e         state_s;
    logic              ex_ready_s;
    logic              head_valid_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;

    logic [DEPTH-1:0]  ord_valid_s;
    logic [RA_W-1:0]   ord_rd_s   [DEPTH];
    logic [DATA_W-1:0] ord_data_s [DEPTH];
    logic [PC_W-1:0]   ord_pc_s   [DEPTH];

    logic              nxt_valid_s;
    logic [RA_W-1:0]   nxt_rd_s;
    logic [DATA_W-1:0] nxt_data_s;
    logic [PC_W-1:0]   nxt_pc_s;

    logic              wb_we_r;
    logic [RA_W-1:0]   wb_addr_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [PC_W-1:0]   wb_pc_r;
    logic [CNT_W-1:0]  retire_cnt_r;

    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;

    writeback_stage_fifo #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W),
        .PC_W   (PC_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .in_rd     (bus.ex_rd),
        .in_data   (bus.ex_result),
        .in_pc     (bus.ex_pc),
        .occupancy (occupancy),
        .ord_valid (ord_valid_s),
        .ord_rd    (ord_rd_s),
        .ord_data  (ord_data_s),
        .ord_pc    (ord_pc_s)
    );

    // Buffer state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= WB_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // State-derived status: acceptance and head presence come from registered state only.
    always_comb begin
        ex_ready_s   = 1'b0;
        head_valid_s = 1'b0;
        case (state_r)
            WB_EMPTY: begin
                ex_ready_s   = reset;
                head_valid_s = 1'b0;
            end
            WB_BUSY: begin
                ex_ready_s   = reset;
                head_valid_s = 1'b1;
            end
            WB_FULL: begin
                ex_ready_s   = 1'b0;
                head_valid_s = 1'b1;
            end
            default: begin
                ex_ready_s   = 1'b0;
                head_valid_s = 1'b0;
            end
        endcase
    end

    // Next buffer state from push/pop and the current fill level.
    always_comb begin
        state_s = state_r;
        case (state_r)
            WB_EMPTY: begin
                if (push_s) begin
                    state_s = WB_BUSY;
                end else begin
                    state_s = WB_EMPTY;
                end
            end
            WB_BUSY: begin
                if (push_s && !pop_s && (occupancy == OCC_W'(DEPTH - 1))) begin
                    state_s = WB_FULL;
                end else if (pop_s && !push_s && (occupancy == OCC_W'(1))) begin
                    state_s = WB_EMPTY;
                end else begin
                    state_s = WB_BUSY;
                end
            end
            WB_FULL: begin
                if (pop_s) begin
                    state_s = WB_BUSY;
                end else begin
                    state_s = WB_FULL;
                end
            end
            default: begin
                state_s = WB_EMPTY;
            end
        endcase
    end

    // An r0 head is discarded on the cycle it sits at the head; a real write leaves on ack.
    assign push_s = bus.ex_valid & ex_ready_s & ~stall;
    assign drop_s = reset & head_valid_s & (ord_rd_s[0] == {RA_W{1'b0}});
    assign pop_s  = reset & ((wb_we_r & bus.wb_ack) | drop_s);

    // Look-ahead: which entry will be at the head after this edge; hold the last one when empty.
    always_comb begin
        nxt_valid_s = 1'b0;
        nxt_rd_s    = wb_addr_r;
        nxt_data_s  = wb_data_r;
        nxt_pc_s    = wb_pc_r;
        if (pop_s) begin
            if (ord_valid_s[1]) begin
                nxt_valid_s = 1'b1;
                nxt_rd_s    = ord_rd_s[1];
                nxt_data_s  = ord_data_s[1];
                nxt_pc_s    = ord_pc_s[1];
            end else if (push_s) begin
                nxt_valid_s = 1'b1;
                nxt_rd_s    = bus.ex_rd;
                nxt_data_s  = bus.ex_result;
                nxt_pc_s    = bus.ex_pc;
            end else begin
                nxt_valid_s = 1'b0;
            end
        end else begin
            if (ord_valid_s[0]) begin
                nxt_valid_s = 1'b1;
                nxt_rd_s    = ord_rd_s[0];
                nxt_data_s  = ord_data_s[0];
                nxt_pc_s    = ord_pc_s[0];
            end else if (push_s) begin
                nxt_valid_s = 1'b1;
                nxt_rd_s    = bus.ex_rd;
                nxt_data_s  = bus.ex_result;
                nxt_pc_s    = bus.ex_pc;
            end else begin
                nxt_valid_s = 1'b0;
            end
        end
    end

    // Registered GPR write port; r0 entries are presented with the request low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wb_we_r   <= 1'b0;
            wb_addr_r <= {RA_W{1'b0}};
            wb_data_r <= {DATA_W{1'b0}};
            wb_pc_r   <= {PC_W{1'b0}};
        end else begin
            wb_we_r   <= nxt_valid_s & (nxt_rd_s != {RA_W{1'b0}});
            wb_addr_r <= nxt_rd_s;
            wb_data_r <= nxt_data_s;
            wb_pc_r   <= nxt_pc_s;
        end
    end

    // Retired-instruction counter; wraps naturally at its width.
    always_ff @(posedge clock) begin
        if (!reset) begin
            retire_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            retire_cnt_r <= retire_cnt_r + CNT_W'(1);
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

`ifdef WB_FORWARD_EN
    // Forwarding search oldest-to-youngest so the youngest match wins.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            if (reset && ord_valid_s[k] && (bus.fwd_rs != {RA_W{1'b0}})
                && (ord_rd_s[k] == bus.fwd_rs)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = ord_data_s[k];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end
`else
    logic unused_fwd_rs_s;

    // Forwarding disabled: the query is ignored and the outputs stay at zero.
    always_comb begin
        unused_fwd_rs_s = ^bus.fwd_rs;
        fwd_hit_s       = 1'b0;
        fwd_data_s      = {DATA_W{1'b0}};
    end
`endif

    assign bus.ex_ready = ex_ready_s;
    assign bus.wb_we    = wb_we_r;
    assign bus.wb_addr  = wb_addr_r;
    assign bus.wb_data  = wb_data_r;
    assign bus.wb_pc    = wb_pc_r;
    assign bus.fwd_hit  = fwd_hit_s;
    assign bus.fwd_data = fwd_data_s;
    assign retire_cnt   = retire_cnt_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// randomized traffic. A queue-based reference model tracks buffer contents,
// retire count and the expected GPR write stream; a monitor compares the DUT
// against it every cycle and scoreboards each completed write.
module tb_writeback_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  occupancy;
    logic [31:0] retire_cnt;

    writeback_stage_if bus ();

    writeback_stage dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .bus        (bus),
        .occupancy  (occupancy),
        .retire_cnt (retire_cnt)
    );

    always #5 clock = ~clock;

    ent_t        m_q[$];
    ent_t        exp_q[$];
    ent_t        m_last;
    logic [31:0] m_retire;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the reference model.
    task automatic step(input logic rst, input logic v, input logic st, input logic ack,
                        input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc,
                        input logic [4:0] rs);
        ent_t e;
        bit   ready;
        reset         = rst;
        stall         = st;
        bus.ex_valid  = v;
        bus.ex_rd     = rd;
        bus.ex_result = res;
        bus.ex_pc     = pc;
        bus.wb_ack    = ack;
        bus.fwd_rs    = rs;
        e             = '{rd, res, pc};
        ready         = rst && (m_q.size() < DEPTH);
        @(posedge clock);
        if (!rst) begin
            m_q.delete();
            exp_q.delete();
            m_retire = 32'd0;
            m_last   = '{5'd0, 32'd0, 32'd0};
        end else begin
            if (m_q.size() > 0 && (m_q[0].rd == 5'd0 || ack)) begin
                void'(m_q.pop_front());
                m_retire = m_retire + 32'd1;
            end
            if (v && ready && !st) begin
                m_q.push_back(e);
                if (rd != 5'd0) exp_q.push_back(e);
            end
            if (m_q.size() > 0) m_last = m_q[0];
        end
        #1;
    endtask

    task automatic idle(input logic ack, input logic [4:0] rs);
        step(1'b1, 1'b0, 1'b0, ack, 5'd0, 32'd0, 32'd0, rs);
    endtask

    // Mid-cycle monitor: compare every output with the model and scoreboard completed writes.
    always @(negedge clock) begin : monitor
        ent_t        e;
        logic        exp_hit;
        logic [31:0] exp_fd;
        check("wb_we", bus.wb_we, (m_q.size() > 0) && (m_q[0].rd != 5'd0));
        check("ex_ready", bus.ex_ready, reset && (m_q.size() < DEPTH));
        check("occupancy", occupancy, m_q.size());
        check("retire_cnt", retire_cnt, m_retire);
        check("wb_addr", bus.wb_addr, m_last.rd);
        check("wb_data", bus.wb_data, m_last.data);
        check("wb_pc", bus.wb_pc, m_last.pc);
        exp_hit = 1'b0;
        exp_fd  = 32'd0;
`ifdef WB_FORWARD_EN
        if (reset && bus.fwd_rs != 5'd0) begin
            foreach (m_q[i]) begin
                if (m_q[i].rd == bus.fwd_rs) begin
                    exp_hit = 1'b1;
                    exp_fd  = m_q[i].data;
                end
            end
        end
`endif
        check("fwd_hit", bus.fwd_hit, exp_hit);
        check("fwd_data", bus.fwd_data, exp_fd);
        if (reset && bus.wb_we && bus.wb_ack) begin
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_addr", bus.wb_addr, e.rd);
                check("sb_data", bus.wb_data, e.data);
                check("sb_pc", bus.wb_pc, e.pc);
            end
        end
    end

    initial begin
        m_last   = '{5'd0, 32'd0, 32'd0};
        m_retire = 32'd0;

        // 1: reset held with a valid offered, then released
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234, 32'h40, 5'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234, 32'h40, 5'd0);
        check("t1_ex_ready_rst", bus.ex_ready, 1'b0);
        check("t1_wb_we_rst", bus.wb_we, 1'b0);
        check("t1_occ_rst", occupancy, 2'd0);
        idle(1'b0, 5'd0);
        check("t1_ex_ready", bus.ex_ready, 1'b1);
        check("t1_occ", occupancy, 2'd0);

        // 2: single write, one-cycle latency, retired on ack
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_00A5, 32'h100, 5'd0);
        check("t2_wb_we", bus.wb_we, 1'b1);
        check("t2_wb_addr", bus.wb_addr, 5'd3);
        check("t2_wb_data", bus.wb_data, 32'hA5);
        idle(1'b1, 5'd0);
        check("t2_wb_we_off", bus.wb_we, 1'b0);
        check("t2_retire", retire_cnt, 32'd1);

        // 3: back-pressure, third offer refused, in-order retire
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'hAAAA_0001, 32'h104, 5'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'hAAAA_0002, 32'h108, 5'd0);
        check("t3_occ_full", occupancy, 2'd2);
        check("t3_ex_ready", bus.ex_ready, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'hAAAA_0009, 32'h10C, 5'd0);
        check("t3_occ_hold", occupancy, 2'd2);
        check("t3_head_rd", bus.wb_addr, 5'd1);
        idle(1'b1, 5'd0);
        check("t3_second_rd", bus.wb_addr, 5'd2);
        idle(1'b1, 5'd0);
        check("t3_retire", retire_cnt, 32'd3);

        // 4: r0 entry dropped without a write; stall blocks acceptance
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'hDEAD, 32'h110, 5'd0);
        check("t4_rd0_we", bus.wb_we, 1'b0);
        idle(1'b0, 5'd0);
        check("t4_retire", retire_cnt, 32'd4);
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h44, 32'h114, 5'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h44, 32'h114, 5'd0);
        check("t4_stall_occ", occupancy, 2'd0);

        // 5: forwarding of the youngest matching entry
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'd11, 32'h118, 5'd5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'd22, 32'h11C, 5'd5);
`ifdef WB_FORWARD_EN
        check("t5_fwd_hit", bus.fwd_hit, 1'b1);
        check("t5_fwd_data", bus.fwd_data, 32'd22);
`else
        check("t5_fwd_hit", bus.fwd_hit, 1'b0);
        check("t5_fwd_data", bus.fwd_data, 32'd0);
`endif
        idle(1'b0, 5'd0);
        check("t5_fwd_rs0", bus.fwd_hit, 1'b0);
        idle(1'b1, 5'd0);
        idle(1'b1, 5'd0);
        check("t5_retire", retire_cnt, 32'd6);

        // 6: reset while two entries are pending discards them
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 32'h120, 5'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'hAA, 32'h124, 5'd0);
        check("t6_occ_pre", occupancy, 2'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        check("t6_occ", occupancy, 2'd0);
        check("t6_wb_we", bus.wb_we, 1'b0);
        check("t6_retire", retire_cnt, 32'd0);
        for (int i = 0; i < 5; i++) idle(1'b1, 5'd0);
        check("t6_retire_after", retire_cnt, 32'd0);

        // 7: randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 7)));
        end

        // Drain whatever is left and confirm every expected write appeared
        for (int i = 0; i < 8; i++) idle(1'b1, 5'd0);
        check("drain_occ", occupancy, 2'd0);
        check("drain_scoreboard", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
